// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor command slew-rate limiter.
package motor_pkg;

   localparam int CMD_W = 11;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      RAMP  = 2'd1,
      DWELL = 2'd2
   } state_t;

   // Clamp a signed command into [-max_mag, +max_mag]; -1024 maps to -max_mag.
   function automatic logic signed [CMD_W-1:0] sat11(input logic signed [CMD_W-1:0] v,
                                                     input int max_mag);
      int vi;
      vi = int'(v);
      if (vi > max_mag) begin
         vi = max_mag;
      end else if (vi < -max_mag) begin
         vi = -max_mag;
      end
      return vi[CMD_W-1:0];
   endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// One wheel channel: saturated target, slew-limited output and the
// HOLD/RAMP/DWELL sequencer that parks the output at zero before a reversal.
module motor_ramp_chan
   import motor_pkg::*;
#(
   parameter int STEP        = 8,
   parameter int DWELL_TICKS = 4,
   parameter int MAX_MAG     = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             load,
   input  logic             clear,
   input  logic             zero_tgt,
   input  logic [CMD_W-1:0] cmd,
   output logic [CMD_W-1:0] out,
   output logic             busy
);

   localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
   localparam logic signed [CMD_W:0]   STEP_S  = (CMD_W+1)'(STEP);
   localparam logic signed [CMD_W-1:0] STEP_11 = CMD_W'(STEP);

   logic signed [CMD_W-1:0] tgt, tgt_nxt;
   logic signed [CMD_W-1:0] out_q, out_nxt;
   state_t                  state, state_nxt;
   logic [DW-1:0]           dwell_cnt, cnt_nxt;

   logic                    forced;
   logic signed [CMD_W-1:0] eff;
   logic signed [CMD_W:0]   diff;
   logic signed [CMD_W-1:0] step_out;

   // A non-zero output heading for a target of the opposite sign is steered to zero first.
   assign forced   = (out_q != '0) && (tgt != '0) && (tgt[CMD_W-1] != out_q[CMD_W-1]);
   assign eff      = forced ? '0 : tgt;
   assign diff     = {eff[CMD_W-1], eff} - {out_q[CMD_W-1], out_q};
   // Stepping by STEP only happens when the goal is further than STEP away, so it cannot overshoot or overflow.
   assign step_out = (diff > STEP_S)  ? out_q + STEP_11 :
                     (diff < -STEP_S) ? out_q - STEP_11 : eff;

   // State register for target, output, sequencer state and dwell counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt       <= '0;
         out_q     <= '0;
         state     <= HOLD;
         dwell_cnt <= '0;
      end else begin
         tgt       <= tgt_nxt;
         out_q     <= out_nxt;
         state     <= state_nxt;
         dwell_cnt <= cnt_nxt;
      end
   end

   // Next-state logic: clear dominates, target writes are independent of the tick-driven ramp.
   always_comb begin
      tgt_nxt   = tgt;
      out_nxt   = out_q;
      state_nxt = state;
      cnt_nxt   = dwell_cnt;
      if (clear) begin
         tgt_nxt   = '0;
         out_nxt   = '0;
         state_nxt = HOLD;
         cnt_nxt   = '0;
      end else begin
         if (load) begin
            tgt_nxt = sat11($signed(cmd), MAX_MAG);
         end else if (zero_tgt) begin
            tgt_nxt = '0;
         end
         if (tick) begin
            case (state)
               DWELL: begin
                  // Output stays parked at zero; the dwell always runs its full length.
                  if (dwell_cnt == DWELL_LAST) begin
                     cnt_nxt   = '0;
                     state_nxt = (tgt == '0) ? HOLD : RAMP;
                  end else begin
                     cnt_nxt = dwell_cnt + 1'b1;
                  end
               end
               default: begin
                  // HOLD with a settled output yields step_out == tgt and stays in HOLD.
                  out_nxt = step_out;
                  if (forced && (step_out == '0)) begin
                     state_nxt = DWELL;
                     cnt_nxt   = '0;
                  end else if (step_out == tgt) begin
                     state_nxt = HOLD;
                  end else begin
                     state_nxt = RAMP;
                  end
               end
            endcase
         end
      end
   end

   assign out  = out_q;
   assign busy = (out_q != tgt) || (state == DWELL);

endmodule

// File: rtl/motor_ramp.sv
// Slew-rate limiter and safety stage in front of the motor controller:
// shared ramp prescaler, command watchdog, emergency stop and two wheel channels.
module motor_ramp
   import motor_pkg::*;
#(
   parameter int STEP        = 8,
   parameter int TICK_DIV    = 500,
   parameter int DWELL_TICKS = 4,
   parameter int WDOG_CYCLES = 2_500_000,
   parameter int MAX_MAG     = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CMD_W-1:0]  cmd_lft,
   input  logic [CMD_W-1:0]  cmd_rht,
   input  logic              cmd_vld,
   input  logic              estop,
   output logic [CMD_W-1:0]  lft,
   output logic [CMD_W-1:0]  rht,
   output logic              ramping,
   output logic              wdog_trip
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

   logic [PW-1:0] pre;
   logic [WW-1:0] wd;
   logic          tick;
   logic          accept;
   logic          expire;
   logic          zero_tgt;
   logic          busy_l;
   logic          busy_r;

   assign tick     = (pre == PRE_LAST);
   // Commands are ignored entirely while estop is held.
   assign accept   = cmd_vld & ~estop;
   assign expire   = (wd == WDOG_LAST);
   // A command arriving on the expiry cycle wins over the trip.
   assign zero_tgt = expire & ~accept;

   // Free-running ramp prescaler; keeps counting through estop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // Command watchdog: restarts on each accepted command, saturates and flags on expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd        <= '0;
         wdog_trip <= 1'b0;
      end else if (accept) begin
         wd        <= '0;
         wdog_trip <= 1'b0;
      end else if (expire) begin
         wdog_trip <= 1'b1;
      end else begin
         wd <= wd + 1'b1;
      end
   end

   motor_ramp_chan #(
      .STEP        (STEP),
      .DWELL_TICKS (DWELL_TICKS),
      .MAX_MAG     (MAX_MAG)
   ) u_lft (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .load     (accept),
      .clear    (estop),
      .zero_tgt (zero_tgt),
      .cmd      (cmd_lft),
      .out      (lft),
      .busy     (busy_l)
   );

   motor_ramp_chan #(
      .STEP        (STEP),
      .DWELL_TICKS (DWELL_TICKS),
      .MAX_MAG     (MAX_MAG)
   ) u_rht (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .load     (accept),
      .clear    (estop),
      .zero_tgt (zero_tgt),
      .cmd      (cmd_rht),
      .out      (rht),
      .busy     (busy_r)
   );

   assign ramping = busy_l | busy_r;

endmodule

// File: tb/tb_motor_ramp.sv
// Scoreboard bench for motor_ramp: stimulus queues expected outputs per ramp tick
// or for the next half-cycle, a monitor pops and compares.
module tb_motor_ramp;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] cmd_lft;
   logic [10:0] cmd_rht;
   logic        cmd_vld;
   logic        estop;
   logic [10:0] lft;
   logic [10:0] rht;
   logic        ramping;
   logic        wdog_trip;

   typedef struct {
      logic [10:0] l;
      logic [10:0] r;
      logic        rmp;
      logic        wd;
      string       nm;
   } exp_t;

   exp_t tick_q[$];
   exp_t now_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   seen_400 = 1'b0;

   logic [1:0] pcnt = 2'd0;
   logic       tick_seen = 1'b0;

   always #5 clk = ~clk;

   motor_ramp #(
      .STEP        (8),
      .TICK_DIV    (TD),
      .DWELL_TICKS (2),
      .WDOG_CYCLES (200),
      .MAX_MAG     (1023)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_lft   (cmd_lft),
      .cmd_rht   (cmd_rht),
      .cmd_vld   (cmd_vld),
      .estop     (estop),
      .lft       (lft),
      .rht       (rht),
      .ramping   (ramping),
      .wdog_trip (wdog_trip)
   );

   // Reference tick phase: a tick edge is one where the divider sat at TD-1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt      <= 2'd0;
         tick_seen <= 1'b0;
      end else begin
         tick_seen <= (pcnt == 2'(TD - 1));
         pcnt      <= (pcnt == 2'(TD - 1)) ? 2'd0 : pcnt + 2'd1;
      end
   end

   function automatic exp_t mk(input int l, input int r, input logic rmp, input logic wd, input string nm);
      exp_t e;
      e.l   = 11'(l);
      e.r   = 11'(r);
      e.rmp = rmp;
      e.wd  = wd;
      e.nm  = nm;
      return e;
   endfunction

   task automatic chk(input exp_t e);
      tests++;
      if (lft !== e.l || rht !== e.r || ramping !== e.rmp || wdog_trip !== e.wd) begin
         fails++;
         $display("FAIL %s: got lft=%0d rht=%0d ramping=%0b wdog_trip=%0b, want lft=%0d rht=%0d ramping=%0b wdog_trip=%0b",
                  e.nm, $signed(lft), $signed(rht), ramping, wdog_trip,
                  $signed(e.l), $signed(e.r), e.rmp, e.wd);
      end
   endtask

   // Monitor: one immediate check per half-cycle, one tick check after each ramp tick.
   initial begin
      forever begin
         @(negedge clk);
         if (now_q.size() > 0) chk(now_q.pop_front());
         if (tick_seen === 1'b1 && tick_q.size() > 0) chk(tick_q.pop_front());
         if (lft === 11'h400 || rht === 11'h400) seen_400 = 1'b1;
      end
   end

   task automatic push_tick(input int l, input int r, input logic rmp, input logic wd, input string nm);
      tick_q.push_back(mk(l, r, rmp, wd, nm));
   endtask

   task automatic push_now(input int l, input int r, input logic rmp, input logic wd, input string nm);
      now_q.push_back(mk(l, r, rmp, wd, nm));
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tick_seen !== 1'b1 && n < 2 * TD + 2);
      #1;
      if (tick_seen !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL tick_wait: no tick seen within %0d cycles", n);
      end
   endtask

   task automatic issue(input int l, input int r);
      cmd_lft = 11'(l);
      cmd_rht = 11'(r);
      cmd_vld = 1'b1;
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
   endtask

   // Wait for the tick scoreboard to empty; optionally re-send the current command as a keepalive.
   task automatic drain(input bit ka, input int max_cyc);
      int n = 0;
      int tk = 0;
      while (tick_q.size() > 0 && n < max_cyc) begin
         @(negedge clk);
         #1;
         n++;
         cmd_vld = 1'b0;
         if (ka && tick_seen === 1'b1) begin
            tk++;
            if (tk % 16 == 0) cmd_vld = 1'b1;
         end
      end
      cmd_vld = 1'b0;
      if (tick_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expected ticks still pending after %0d cycles", tick_q.size(), n);
         tick_q.delete();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n   = 1'b0;
      cmd_lft = '0;
      cmd_rht = '0;
      cmd_vld = 1'b0;
      estop   = 1'b0;

      // Reset and asynchronous reset mid-ramp
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      push_now(0, 0, 0, 0, "reset_release");
      wait_tick();
      issue(100, 0);
      for (int k = 1; k <= 3; k++) push_tick(8 * k, 0, 1, 0, "pre_reset_ramp");
      drain(0, 40);
      @(posedge clk);
      #2 rst_n = 1'b0;
      push_now(0, 0, 0, 0, "async_reset_mid_ramp");
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Ramp up 0 -> 100
      wait_tick();
      issue(100, 0);
      for (int k = 1; k <= 12; k++) push_tick(8 * k, 0, 1, 0, "ramp_up");
      push_tick(100, 0, 0, 0, "ramp_up_done");
      drain(0, 100);

      // Down to +20, then reverse to -20 through a dwell
      wait_tick();
      issue(20, 0);
      for (int k = 1; k <= 10; k++) push_tick(100 - 8 * k, 0, (k < 10), 0, "ramp_down");
      drain(0, 100);
      wait_tick();
      issue(-20, 0);
      push_tick(12, 0, 1, 0, "reverse_to_zero");
      push_tick(4, 0, 1, 0, "reverse_to_zero");
      push_tick(0, 0, 1, 0, "reverse_zero");
      push_tick(0, 0, 1, 0, "reverse_dwell");
      push_tick(0, 0, 1, 0, "reverse_dwell");
      push_tick(-8, 0, 1, 0, "reverse_neg");
      push_tick(-16, 0, 1, 0, "reverse_neg");
      push_tick(-20, 0, 0, 0, "reverse_done");
      drain(0, 60);

      // Saturation of -1024 and a full-scale reversal
      wait_tick();
      issue(-20, 'h400);
      for (int k = 1; k <= 127; k++) push_tick(-20, -8 * k, 1, 0, "sat_neg");
      push_tick(-20, -1023, 0, 0, "sat_neg_done");
      drain(1, 700);
      wait_tick();
      issue(-20, 1023);
      for (int k = 1; k <= 127; k++) push_tick(-20, -1023 + 8 * k, 1, 0, "cross_neg");
      push_tick(-20, 0, 1, 0, "cross_zero");
      push_tick(-20, 0, 1, 0, "cross_dwell");
      push_tick(-20, 0, 1, 0, "cross_dwell");
      for (int k = 1; k <= 127; k++) push_tick(-20, 8 * k, 1, 0, "cross_pos");
      push_tick(-20, 1023, 0, 0, "cross_done");
      drain(1, 1300);

      // Watchdog trip after 200 idle cycles, decay to zero
      wait_tick();
      issue(-20, 1023);
      repeat (199) @(posedge clk);
      #1 push_now(-20, 1023, 0, 0, "wdog_before_expiry");
      @(posedge clk);
      #1 push_now(-20, 1023, 1, 1, "wdog_trip");
      for (int m = 1; m <= 128; m++)
         push_tick((m == 1) ? -12 : (m == 2) ? -4 : 0, (m < 128) ? 1023 - 8 * m : 0,
                   (m < 128), 1, "wdog_decay");
      drain(0, 600);
      wait_tick();
      issue(0, 0);
      push_now(0, 0, 0, 0, "wdog_clear");
      repeat (199) @(posedge clk);
      #1 cmd_vld = 1'b1;
      @(posedge clk);
      #1 cmd_vld = 1'b0;
      push_now(0, 0, 0, 0, "wdog_expiry_race");
      repeat (5) @(posedge clk);
      #1 push_now(0, 0, 0, 0, "wdog_expiry_race_after");

      // Emergency stop mid-ramp
      wait_tick();
      issue(100, 100);
      for (int k = 1; k <= 6; k++) push_tick(8 * k, 8 * k, 1, 0, "pre_estop");
      repeat (6) wait_tick();
      estop   = 1'b1;
      cmd_lft = 11'(200);
      cmd_rht = 11'(200);
      cmd_vld = 1'b1;
      @(posedge clk);
      #1 push_now(0, 0, 0, 0, "estop_clear");
      @(posedge clk);
      #1 push_now(0, 0, 0, 0, "estop_cmd_ignored");
      estop   = 1'b0;
      cmd_vld = 1'b0;
      for (int k = 1; k <= 3; k++) push_tick(0, 0, 0, 0, "estop_release_hold");
      drain(0, 40);
      wait_tick();
      issue(16, 0);
      push_tick(8, 0, 1, 0, "post_estop_cmd");
      push_tick(16, 0, 0, 0, "post_estop_done");
      drain(0, 40);

      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (seen_400) begin
         fails++;
         $display("FAIL never_0x400: got an output of 11'h400, want none");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
